// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS32 datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and counts retired instructions.
module mips_multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Opcode,
  input  logic             memReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic [1:0]       PCSource,
  output logic             illegalOp,
  output logic [CNT_W-1:0] instrCount,
  output logic [3:0]       state
);

  localparam int unsigned ST_W = 4;
  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [ST_W-1:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RCOMP   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   retire_c;
  logic   illegal_set_c;

  // State, sticky illegal flag and retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      illegalOp  <= 1'b0;
      instrCount <= '0;
    end else begin
      state_q <= state_d;
      if (illegal_set_c) illegalOp <= 1'b1;
      if (retire_c) instrCount <= instrCount + CNT_W'(1);
    end
  end

  assign state = ST_W'(state_q);

  // Next-state and control decode; only FETCH looks at memReady for its enables
  always_comb begin
    state_d       = state_q;
    retire_c      = 1'b0;
    illegal_set_c = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUop         = 2'b00;
    PCSource      = 2'b00;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = memReady;
        PCWrite = memReady;
        if (memReady) state_d = S_DECODE;
      end

      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEX;
          OP_J:          state_d = S_JUMP;
          default: begin
            state_d       = S_FETCH;
            illegal_set_c = 1'b1;
          end
        endcase
      end

      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end

      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (memReady) begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        state_d = S_RCOMP;
      end

      S_RCOMP: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end

      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = S_FETCH;
        retire_c    = 1'b1;
      end

      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end

      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end

      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: per-instruction cycle plans from the
// instruction-class rules feed an expected queue that a negedge monitor drains.
module tb_mips_multicycle_control;

  localparam int unsigned CNT_W = 4;

  // Control vector bit masks, ordered as in the monitor's concatenation
  localparam logic [15:0] PCW       = 16'h8000;
  localparam logic [15:0] PCWC      = 16'h4000;
  localparam logic [15:0] IORD      = 16'h2000;
  localparam logic [15:0] MR        = 16'h1000;
  localparam logic [15:0] MW        = 16'h0800;
  localparam logic [15:0] IRW       = 16'h0400;
  localparam logic [15:0] M2R       = 16'h0200;
  localparam logic [15:0] RDST      = 16'h0100;
  localparam logic [15:0] RW        = 16'h0080;
  localparam logic [15:0] SRCA      = 16'h0040;
  localparam logic [15:0] SRCB_4    = 16'h0010;
  localparam logic [15:0] SRCB_IMM  = 16'h0020;
  localparam logic [15:0] SRCB_SH   = 16'h0030;
  localparam logic [15:0] ALUOP_SUB = 16'h0004;
  localparam logic [15:0] ALUOP_R   = 16'h0008;
  localparam logic [15:0] PCSRC_OUT = 16'h0001;
  localparam logic [15:0] PCSRC_J   = 16'h0002;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       Opcode;
  logic             memReady;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       ALUSrcB, ALUop, PCSource;
  logic             illegalOp;
  logic [CNT_W-1:0] instrCount;
  logic [3:0]       state;

  mips_multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .memReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource),
    .illegalOp(illegalOp), .instrCount(instrCount), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       st;
    logic [15:0]      ctrl;
    logic [CNT_W-1:0] cnt;
    logic             ill;
  } exp_t;

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             exp_ill = 1'b0;
  int               n_cmp = 0;
  int               n_err = 0;

  function automatic logic [15:0] act_ctrl();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per clock, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("state", 32'(state), 32'(e.st));
      check($sformatf("ctrl(st%0d)", e.st), 32'(act_ctrl()), 32'(e.ctrl));
      check("instrCount", 32'(instrCount), 32'(e.cnt));
      check("illegalOp", 32'(illegalOp), 32'(e.ill));
    end
  end

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic cyc(input logic [3:0] st, input logic [15:0] c, input logic [5:0] op,
                     input logic rdy);
    exp_t e;
    @(posedge clk); #1;
    Opcode   = op;
    memReady = rdy;
    e.st = st; e.ctrl = c; e.cnt = exp_cnt; e.ill = exp_ill;
    sb.push_back(e);
  endtask

  task automatic release_rst();
    exp_t e;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    memReady = rb();
    e.st = 4'd0; e.ctrl = 16'h0; e.cnt = exp_cnt; e.ill = exp_ill;
    sb.push_back(e);
  endtask

  // One instruction: fetch waits, decode, then the class-specific steps
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) cyc(4'd1, MR | SRCB_4, op, 1'b0);
    cyc(4'd1, MR | SRCB_4 | IRW | PCW, op, 1'b1);
    cyc(4'd2, SRCB_SH, op, rb());
    case (op)
      6'b000000: begin
        cyc(4'd7, SRCA | ALUOP_R, op, rb());
        cyc(4'd8, RW | RDST, op, rb());
        exp_cnt++;
      end
      6'b100011: begin
        cyc(4'd3, SRCA | SRCB_IMM, op, rb());
        for (int i = 0; i < mw; i++) cyc(4'd4, MR | IORD, op, 1'b0);
        cyc(4'd4, MR | IORD, op, 1'b1);
        cyc(4'd5, RW | M2R, op, rb());
        exp_cnt++;
      end
      6'b101011: begin
        cyc(4'd3, SRCA | SRCB_IMM, op, rb());
        for (int i = 0; i < mw; i++) cyc(4'd6, MW | IORD, op, 1'b0);
        cyc(4'd6, MW | IORD, op, 1'b1);
        exp_cnt++;
      end
      6'b000100: begin
        cyc(4'd9, SRCA | ALUOP_SUB | PCWC | PCSRC_OUT, op, rb());
        exp_cnt++;
      end
      6'b001000: begin
        cyc(4'd10, SRCA | SRCB_IMM, op, rb());
        cyc(4'd11, RW, op, rb());
        exp_cnt++;
      end
      6'b000010: begin
        cyc(4'd12, PCW | PCSRC_J, op, rb());
        exp_cnt++;
      end
      default: exp_ill = 1'b1;
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
    int unsigned r = $urandom_range(0, 7);
    if (r < 6) return ops[r];
    return 6'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    Opcode   = 6'h00;
    memReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(act_ctrl()), 32'd0);
    check("rst_count", 32'(instrCount), 32'd0);
    check("rst_illegal", 32'(illegalOp), 32'd0);
    release_rst();

    run_instr(6'h00, 0, 0);
    run_instr(6'h23, 0, 3);
    run_instr(6'h00, 2, 0);
    run_instr(6'h04, 0, 0);
    run_instr(6'h02, 1, 0);
    run_instr(6'h3f, 0, 0);
    run_instr(6'h08, 0, 0);
    run_instr(6'h2b, 0, 2);
    run_instr(6'h23, 0, 0);

    for (int n = 0; n < 60; n++)
      run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3));
    run_instr(6'h3f, 0, 0);

    // Abort a store mid-wait with an asynchronous reset
    cyc(4'd1, MR | SRCB_4 | IRW | PCW, 6'h2b, 1'b1);
    cyc(4'd2, SRCB_SH, 6'h2b, 1'b1);
    cyc(4'd3, SRCA | SRCB_IMM, 6'h2b, 1'b1);
    @(posedge clk); #1;
    memReady = 1'b0;
    check("memwr_before_rst", 32'(MemWrite), 32'd1);
    check("state_before_rst", 32'(state), 32'd6);
    check("ill_before_rst", 32'(illegalOp), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ctrl", 32'(act_ctrl()), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_count", 32'(instrCount), 32'd0);
    check("abort_illegal", 32'(illegalOp), 32'd0);
    exp_cnt = '0;
    exp_ill = 1'b0;
    @(posedge clk);
    release_rst();
    run_instr(6'h00, 0, 0);
    run_instr(6'h2b, 1, 1);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
